// File: rtl/the_data_memory_pkg.sv
// Shared types and sizes for the processor data memory and the execute stage.
// Optional build macro: DATA_MEM_WRITE_FORWARD_EN (read ports see pending writes).
package the_data_memory_pkg;

  localparam int unsigned DATA_ADDR_W  = 9;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned DATA_DEPTH   = 512;
  localparam int unsigned NUM_RD_PORTS = 4;
  localparam int unsigned NUM_WR_PORTS = 4;

  typedef logic [DATA_W-1:0]      data_word_t;
  typedef logic [DATA_ADDR_W-1:0] data_addr_t;

endpackage

// File: rtl/the_data_memory_read_port.sv
// One combinational read port of the data memory.
// With DATA_MEM_WRITE_FORWARD_EN, pending writes bypass storage (port 4 highest).
module data_mem_read_port
  import the_data_memory_pkg::*;
#(
  parameter int unsigned AW    = DATA_ADDR_W,
  parameter int unsigned DW    = DATA_W,
  parameter int unsigned DEPTH = DATA_DEPTH
) (
  input  logic [AW-1:0]           rd_addr_i,
  input  logic [DW-1:0]           mem_i [DEPTH],
`ifdef DATA_MEM_WRITE_FORWARD_EN
  input  logic [NUM_WR_PORTS-1:0] wr_en_i,
  input  logic [AW-1:0]           wr_addr_i [NUM_WR_PORTS],
  input  logic [DW-1:0]           wr_data_i [NUM_WR_PORTS],
`endif
  output logic [DW-1:0]           rd_data_o
);

  always_comb begin
    rd_data_o = mem_i[rd_addr_i];
`ifdef DATA_MEM_WRITE_FORWARD_EN
    // Ascending scan so the highest-numbered matching port is the one that sticks.
    for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
      if (wr_en_i[p] && (wr_addr_i[p] == rd_addr_i)) begin
        rd_data_o = wr_data_i[p];
      end
    end
`endif
  end

endmodule

// File: rtl/the_data_memory.sv
// Quad-read / quad-write 32-bit data memory, async active-low clear.
// Optional build macro: DATA_MEM_WRITE_FORWARD_EN.
module the_data_memory #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] data_rd1,
  input  logic [ADDR_W-1:0] data_rd2,
  input  logic [ADDR_W-1:0] data_rd3,
  input  logic [ADDR_W-1:0] data_rd4,
  input  logic [ADDR_W-1:0] data_wr1,
  input  logic [ADDR_W-1:0] data_wr2,
  input  logic [ADDR_W-1:0] data_wr3,
  input  logic [ADDR_W-1:0] data_wr4,
  input  logic [DATA_W-1:0] data_wr1_data,
  input  logic [DATA_W-1:0] data_wr2_data,
  input  logic [DATA_W-1:0] data_wr3_data,
  input  logic [DATA_W-1:0] data_wr4_data,
  input  logic              data_wr1_enable,
  input  logic              data_wr2_enable,
  input  logic              data_wr3_enable,
  input  logic              data_wr4_enable,
  output logic [DATA_W-1:0] data_rd1_out,
  output logic [DATA_W-1:0] data_rd2_out,
  output logic [DATA_W-1:0] data_rd3_out,
  output logic [DATA_W-1:0] data_rd4_out
);
  import the_data_memory_pkg::*;

  logic [DATA_W-1:0]       mem_q   [DEPTH];
  logic [NUM_WR_PORTS-1:0] wr_en;
  logic [ADDR_W-1:0]       wr_addr [NUM_WR_PORTS];
  logic [DATA_W-1:0]       wr_data [NUM_WR_PORTS];
  logic [ADDR_W-1:0]       rd_addr [NUM_RD_PORTS];
  logic [DATA_W-1:0]       rd_data [NUM_RD_PORTS];

  always_comb begin
    wr_en      = {data_wr4_enable, data_wr3_enable, data_wr2_enable, data_wr1_enable};
    wr_addr[0] = data_wr1;
    wr_addr[1] = data_wr2;
    wr_addr[2] = data_wr3;
    wr_addr[3] = data_wr4;
    wr_data[0] = data_wr1_data;
    wr_data[1] = data_wr2_data;
    wr_data[2] = data_wr3_data;
    wr_data[3] = data_wr4_data;
    rd_addr[0] = data_rd1;
    rd_addr[1] = data_rd2;
    rd_addr[2] = data_rd3;
    rd_addr[3] = data_rd4;
  end

  // Ports applied 1..4 in order: a later non-blocking write to the same word wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
        if (wr_en[p]) begin
          mem_q[wr_addr[p]] <= wr_data[p];
        end
      end
    end
  end

`ifdef DATA_MEM_WRITE_FORWARD_EN
  // Forwarding is suppressed while reset is held so outputs read as cleared.
  logic [NUM_WR_PORTS-1:0] fwd_en;
  assign fwd_en = wr_en & {NUM_WR_PORTS{reset}};
`endif

  for (genvar r = 0; r < NUM_RD_PORTS; r++) begin : g_rd
    data_mem_read_port #(
      .AW    (ADDR_W),
      .DW    (DATA_W),
      .DEPTH (DEPTH)
    ) u_rd (
      .rd_addr_i (rd_addr[r]),
      .mem_i     (mem_q),
`ifdef DATA_MEM_WRITE_FORWARD_EN
      .wr_en_i   (fwd_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
`endif
      .rd_data_o (rd_data[r])
    );
  end

  assign data_rd1_out = rd_data[0];
  assign data_rd2_out = rd_data[1];
  assign data_rd3_out = rd_data[2];
  assign data_rd4_out = rd_data[3];

endmodule

// File: tb/tb_the_data_memory.sv
// Self-checking bench for the_data_memory: directed cases plus randomized traffic
// against an array-based reference memory.
`timescale 1ns/1ps
module tb_the_data_memory;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  ra [4];
  logic [8:0]  wa [4];
  logic [31:0] wd [4];
  logic        we [4];
  logic [31:0] ro [4];

  logic [31:0] model [512];
  int          n_pass = 0;
  int          n_total = 0;

  always #10 clock = ~clock;

  the_data_memory #(.ADDR_W(9), .DATA_W(32), .DEPTH(512)) dut (
    .clock           (clock),
    .reset           (reset),
    .data_rd1        (ra[0]),
    .data_rd2        (ra[1]),
    .data_rd3        (ra[2]),
    .data_rd4        (ra[3]),
    .data_wr1        (wa[0]),
    .data_wr2        (wa[1]),
    .data_wr3        (wa[2]),
    .data_wr4        (wa[3]),
    .data_wr1_data   (wd[0]),
    .data_wr2_data   (wd[1]),
    .data_wr3_data   (wd[2]),
    .data_wr4_data   (wd[3]),
    .data_wr1_enable (we[0]),
    .data_wr2_enable (we[1]),
    .data_wr3_enable (we[2]),
    .data_wr4_enable (we[3]),
    .data_rd1_out    (ro[0]),
    .data_rd2_out    (ro[1]),
    .data_rd3_out    (ro[2]),
    .data_rd4_out    (ro[3])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 512; i++) model[i] = 32'h0;
  endtask

  task automatic idle();
    for (int p = 0; p < 4; p++) begin
      we[p] = 1'b0;
      wa[p] = '0;
      wd[p] = '0;
    end
  endtask

  // Expected read value: cleared in reset, otherwise stored word, optionally
  // overridden by the highest-numbered enabled writer to that address.
  function automatic logic [31:0] expect_rd(input logic [8:0] a);
    if (!reset) return 32'h0;
`ifdef DATA_MEM_WRITE_FORWARD_EN
    for (int p = 3; p >= 0; p--)
      if (we[p] && wa[p] == a) return wd[p];
`endif
    return model[a];
  endfunction

  // Reference storage update: collect the final value per address, highest port last.
  always @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < 4; p++)
        if (we[p]) model[wa[p]] = wd[p];
    end
  end

  always @(negedge clock) begin
    for (int r = 0; r < 4; r++)
      check($sformatf("cmp_rd%0d_addr%0d", r + 1, ra[r]), ro[r], expect_rd(ra[r]));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    ra[0] = 9'd0; ra[1] = 9'd5; ra[2] = 9'd255; ra[3] = 9'd511;
    clear_model();
    #2 reset = 1'b0;
    #1;
    check("reset_rd1_a0",   ro[0], 32'h0);
    check("reset_rd2_a5",   ro[1], 32'h0);
    check("reset_rd3_a255", ro[2], 32'h0);
    check("reset_rd4_a511", ro[3], 32'h0);
    #1 reset = 1'b1;

    // single write / read
    step();
    we[0] = 1'b1; wa[0] = 9'd3; wd[0] = 32'hDEADBEEF;
    step();
    idle();
    ra[1] = 9'd3; ra[0] = 9'd4;
    #2;
    check("single_rd2_a3", ro[1], 32'hDEADBEEF);
    check("single_rd1_a4", ro[0], 32'h0);

    // parallel writes
    for (int p = 0; p < 4; p++) begin
      we[p] = 1'b1; wa[p] = 9'(10 + p); wd[p] = 32'(8'h11 * (p + 1));
    end
    step();
    idle();
    for (int p = 0; p < 4; p++) ra[p] = 9'(10 + p);
    #2;
    check("par_rd1_a10", ro[0], 32'h11);
    check("par_rd2_a11", ro[1], 32'h22);
    check("par_rd3_a12", ro[2], 32'h33);
    check("par_rd4_a13", ro[3], 32'h44);

    // collision: port 4 beats port 1
    we[0] = 1'b1; wa[0] = 9'd7; wd[0] = 32'hAAAA0000;
    we[3] = 1'b1; wa[3] = 9'd7; wd[3] = 32'h5555FFFF;
    step();
    idle();
    ra[0] = 9'd7;
    #2 check("collide_a7", ro[0], 32'h5555FFFF);

    // forwarding / read-during-write on a never-written address
    we[1] = 1'b1; wa[1] = 9'd20; wd[1] = 32'hCAFEF00D;
    ra[2] = 9'd20;
    #2;
`ifdef DATA_MEM_WRITE_FORWARD_EN
    check("rdw_before_edge", ro[2], 32'hCAFEF00D);
`else
    check("rdw_before_edge", ro[2], 32'h0);
`endif
    step();
    idle();
    #2 check("rdw_after_edge", ro[2], 32'hCAFEF00D);

    // reset mid-operation
    we[0] = 1'b1; wa[0] = 9'd100; wd[0] = 32'h12345678;
    step();
    idle();
    ra[0] = 9'd100;
    #2 check("mid_before_reset", ro[0], 32'h12345678);
    #1 reset = 1'b0;
    clear_model();
    #2 check("mid_reset_clears", ro[0], 32'h0);
    we[1] = 1'b1; wa[1] = 9'd100; wd[1] = 32'hFFFF0001;
    step();
    idle();
    reset = 1'b1;
    #2 check("mid_write_dropped", ro[0], 32'h0);

    // randomized traffic: narrow address window forces collisions and read-during-write
    for (int c = 0; c < 400; c++) begin
      step();
      reset = 1'b1;
      for (int p = 0; p < 4; p++) begin
        we[p] = ($urandom_range(0, 2) != 0);
        wa[p] = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
        wd[p] = $urandom;
        ra[p] = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 79) == 0) begin
        #3 reset = 1'b0;
        clear_model();
      end
    end
    step();
    reset = 1'b1;
    idle();
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
